// File: rtl/tusca_sched_pkg.sv
// Shared state codes and counter width derivations for the TUSCA measurement scheduler.
package tusca_sched_pkg;

  localparam logic [3:0] ST_INICIAL        = 4'd0;
  localparam logic [3:0] ST_MEDE           = 4'd1;
  localparam logic [3:0] ST_AGUARDA_MEDIDA = 4'd2;
  localparam logic [3:0] ST_TRANSMITE      = 4'd3;
  localparam logic [3:0] ST_AGUARDA_TX     = 4'd4;
  localparam logic [3:0] ST_ESPERA         = 4'd5;
  localparam logic [3:0] ST_CONFIG         = 4'd6;
  localparam logic [3:0] ST_AGUARDA_CONFIG = 4'd7;
  localparam logic [3:0] ST_FALHA          = 4'd8;

  // Attempts never exceed 3, so two bits always hold the count.
  localparam int TENT_W = 2;

  function automatic int largura(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tusca_sched_medida_contador.sv
// Generic modulo-M counter with synchronous clear (zera), enable (conta) and terminal flag (fim).
module contador_m
  import tusca_sched_pkg::*;
#(
  parameter int M = 10,
  parameter int W = largura(M)
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [W-1:0] valor_q, valor_d;

  assign fim = (valor_q == W'(M - 1));

  always_comb begin
    valor_d = valor_q;
    if (zera)
      valor_d = '0;
    else if (conta)
      valor_d = fim ? '0 : valor_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      valor_q <= '0;
    else
      valor_q <= valor_d;
  end

endmodule

// File: rtl/tusca_sched_medida.sv
// Periodic measurement scheduler with timeout/retry and deferred config reception.
// Optional: define TUSCA_TX_FALHA_EN to send a frame after a sensor failure.
module tusca_sched_medida
  import tusca_sched_pkg::*;
#(
  parameter int PERIODO_DELAY  = 100_000_000,
  parameter int TIMEOUT_MEDIDA = 50_000_000,
  parameter int MAX_TENTATIVAS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        definir_config,
  input  logic        pronto_medida,
  input  logic        erro_medida,
  input  logic        pronto_config,
  input  logic        pronto_transmissao,
  output logic        medir_dht11,
  output logic        receber_config,
  output logic        transmite_medida,
  output logic        falha_sensor,
  output logic        ocupado,
  output logic [3:0]  db_estado,
  output logic [1:0]  db_tentativas
);

  localparam logic [TENT_W-1:0] MAX_T = TENT_W'(MAX_TENTATIVAS);

  logic [3:0]        estado_q, estado_d;
  logic [TENT_W-1:0] tent_q, tent_d, tent_nova;
  logic              pend_q, pend_d;
  logic              start_lat_q, start_lat_d;
  logic              ret_esp_q, ret_esp_d;
  logic              falha_q, falha_d;
  logic              medir_q, medir_d;
  logic              rec_q, rec_d;
  logic              tx_q, tx_d;
  logic              tmo_fim, dly_fim;
  logic              dly_zera, dly_conta;

  contador_m #(.M(TIMEOUT_MEDIDA)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (estado_q == ST_MEDE),
    .conta (estado_q == ST_AGUARDA_MEDIDA),
    .fim   (tmo_fim)
  );

  // The delay count survives a config detour so the period is not stretched.
  assign dly_zera  = (estado_d == ST_ESPERA) && (estado_q != ST_ESPERA)
                     && (estado_q != ST_AGUARDA_CONFIG);
  assign dly_conta = (estado_q == ST_ESPERA) && !pend_q;

  contador_m #(.M(PERIODO_DELAY)) u_delay (
    .clock (clock),
    .reset (reset),
    .zera  (dly_zera),
    .conta (dly_conta),
    .fim   (dly_fim)
  );

  always_comb begin
    estado_d    = estado_q;
    tent_d      = tent_q;
    start_lat_d = start_lat_q;
    ret_esp_d   = ret_esp_q;
    falha_d     = falha_q;
    tent_nova   = tent_q + 1'b1;
    case (estado_q)
      ST_INICIAL: begin
        if (pend_q || definir_config) begin
          estado_d    = ST_CONFIG;
          start_lat_d = start_lat_q | start;
          ret_esp_d   = 1'b0;
        end else if (start || start_lat_q) begin
          estado_d    = ST_MEDE;
          start_lat_d = 1'b0;
          tent_d      = '0;
        end
      end
      ST_MEDE: estado_d = ST_AGUARDA_MEDIDA;
      ST_AGUARDA_MEDIDA: begin
        if (pronto_medida && !erro_medida) begin
          falha_d  = 1'b0;
          estado_d = ST_TRANSMITE;
        end else if (erro_medida || tmo_fim) begin
          tent_d = tent_nova;
          if (tent_nova < MAX_T) begin
            estado_d = ST_MEDE;
          end else begin
            estado_d = ST_FALHA;
            falha_d  = 1'b1;
          end
        end
      end
      ST_TRANSMITE: estado_d = ST_AGUARDA_TX;
      ST_AGUARDA_TX: if (pronto_transmissao) estado_d = ST_ESPERA;
      ST_FALHA: begin
        falha_d = 1'b1;
`ifdef TUSCA_TX_FALHA_EN
        estado_d = ST_TRANSMITE;
`else
        estado_d = ST_ESPERA;
`endif
      end
      ST_ESPERA: begin
        if (pend_q) begin
          estado_d  = ST_CONFIG;
          ret_esp_d = 1'b1;
        end else if (dly_fim) begin
          estado_d = ST_MEDE;
          tent_d   = '0;
        end
      end
      ST_CONFIG: estado_d = ST_AGUARDA_CONFIG;
      ST_AGUARDA_CONFIG: if (pronto_config) estado_d = ret_esp_q ? ST_ESPERA : ST_INICIAL;
      default: estado_d = ST_INICIAL;
    endcase
    // Entry to CONFIG consumes the request, including one arriving that same cycle.
    pend_d  = (pend_q || definir_config) && (estado_d != ST_CONFIG);
    medir_d = (estado_d == ST_MEDE);
    rec_d   = (estado_d == ST_CONFIG);
    tx_d    = (estado_d == ST_TRANSMITE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= ST_INICIAL;
      tent_q      <= '0;
      pend_q      <= 1'b0;
      start_lat_q <= 1'b0;
      ret_esp_q   <= 1'b0;
      falha_q     <= 1'b0;
      medir_q     <= 1'b0;
      rec_q       <= 1'b0;
      tx_q        <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      tent_q      <= tent_d;
      pend_q      <= pend_d;
      start_lat_q <= start_lat_d;
      ret_esp_q   <= ret_esp_d;
      falha_q     <= falha_d;
      medir_q     <= medir_d;
      rec_q       <= rec_d;
      tx_q        <= tx_d;
    end
  end

  assign medir_dht11      = medir_q;
  assign receber_config   = rec_q;
  assign transmite_medida = tx_q;
  assign falha_sensor     = falha_q;
  assign ocupado          = !((estado_q == ST_INICIAL) || (estado_q == ST_ESPERA));
  assign db_estado        = estado_q;
  assign db_tentativas    = tent_q;

endmodule

// File: tb/tb_tusca_sched_medida.sv
// Directed bench for tusca_sched_medida with PERIODO_DELAY=20, TIMEOUT_MEDIDA=10, MAX_TENTATIVAS=3.
module tb_tusca_sched_medida;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, definir_config = 1'b0, pronto_medida = 1'b0, erro_medida = 1'b0;
  logic       pronto_config = 1'b0, pronto_transmissao = 1'b0;
  logic       medir_dht11, receber_config, transmite_medida, falha_sensor, ocupado;
  logic [3:0] db_estado;
  logic [1:0] db_tentativas;

  int total = 0;
  int bad = 0;
  int n, ntx;

  tusca_sched_medida #(
    .PERIODO_DELAY(20), .TIMEOUT_MEDIDA(10), .MAX_TENTATIVAS(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .definir_config(definir_config),
    .pronto_medida(pronto_medida), .erro_medida(erro_medida), .pronto_config(pronto_config),
    .pronto_transmissao(pronto_transmissao), .medir_dht11(medir_dht11),
    .receber_config(receber_config), .transmite_medida(transmite_medida),
    .falha_sensor(falha_sensor), .ocupado(ocupado), .db_estado(db_estado),
    .db_tentativas(db_tentativas)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_medir(output int cyc, output int txs);
    cyc = 0;
    txs = 0;
    do begin
      tick();
      cyc++;
      if (transmite_medida) txs++;
    end while (!medir_dht11 && cyc < 200);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_medir"}, medir_dht11, 0);
    check({tag, "_rec"}, receber_config, 0);
    check({tag, "_tx"}, transmite_medida, 0);
    check({tag, "_falha"}, falha_sensor, 0);
    check({tag, "_ocupado"}, ocupado, 0);
    check({tag, "_estado"}, db_estado, 0);
    check({tag, "_tent"}, db_tentativas, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset state
    tick(); tick();
    check_idle_outputs("rst");
    reset = 1'b1;
    tick();
    check("rst_hold_estado", db_estado, 0);

    // drive into AGUARDA_TX, then abort with reset
    start = 1'b1; tick(); start = 1'b0;
    check("t1_medir", medir_dht11, 1);
    check("t1_estado_mede", db_estado, 1);
    tick();
    check("t1_estado_ag", db_estado, 2);
    pronto_medida = 1'b1; tick(); pronto_medida = 1'b0;
    check("t1_tx", transmite_medida, 1);
    tick();
    check("t1_estado_agtx", db_estado, 4);
    reset = 1'b0; #1;
    check_idle_outputs("t1_abort");
    tick();
    reset = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check("t1_restart_medir", medir_dht11, 1);

    // test 2: normal cycle, pronto_medida 5 cycles after medir
    tick(); tick(); tick(); tick();
    check("t2_no_tx_early", transmite_medida, 0);
    pronto_medida = 1'b1; tick(); pronto_medida = 1'b0;
    check("t2_tx", transmite_medida, 1);
    check("t2_estado_tx", db_estado, 3);
    tick();
    check("t2_tx_single", transmite_medida, 0);
    check("t2_ocupado", ocupado, 1);
    tick(); tick();
    pronto_transmissao = 1'b1; tick(); pronto_transmissao = 1'b0;
    check("t2_espera", db_estado, 5);
    check("t2_espera_ocupado", ocupado, 0);
    wait_medir(n, ntx);
    check("t2_espera_len", n, 20);
    check("t2_espera_no_tx", ntx, 0);
    check("t2_tent_clear", db_tentativas, 0);

    // test 3/4: no response, retries 11 cycles apart
    wait_medir(n, ntx);
    check("t3_retry1_gap", n, 11);
    check("t3_tent1", db_tentativas, 1);
    wait_medir(n, ntx);
    check("t3_retry2_gap", n, 11);
    check("t3_tent2", db_tentativas, 2);
    for (int i = 0; i < 11; i++) tick();
    check("t3_falha_estado", db_estado, 8);
    check("t3_falha", falha_sensor, 1);
    check("t3_tent3", db_tentativas, 3);
    check("t3_no_medir", medir_dht11, 0);
    tick();
`ifdef TUSCA_TX_FALHA_EN
    check("t4_tx_estado", db_estado, 3);
    check("t4_tx", transmite_medida, 1);
    tick();
    pronto_transmissao = 1'b1; tick(); pronto_transmissao = 1'b0;
    check("t4_espera", db_estado, 5);
`else
    check("t3_espera", db_estado, 5);
    check("t3_no_tx", transmite_medida, 0);
`endif
    check("t3_falha_held", falha_sensor, 1);
    wait_medir(n, ntx);
    check("t3_espera_len", n, 20);
    check("t3_espera_no_tx", ntx, 0);
    check("t3_tent_clear", db_tentativas, 0);

    // test 5: config requested mid-measurement is deferred to ESPERA
    tick();
    definir_config = 1'b1; tick(); definir_config = 1'b0;
    check("t5_defer_estado", db_estado, 2);
    check("t5_defer_rec", receber_config, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_start_ignored", db_estado, 2);
    pronto_medida = 1'b1; tick(); pronto_medida = 1'b0;
    check("t4_falha_cleared", falha_sensor, 0);
    check("t5_tx_rec", receber_config, 0);
    tick();
    pronto_transmissao = 1'b1; tick(); pronto_transmissao = 1'b0;
    check("t5_espera", db_estado, 5);
    check("t5_espera_rec", receber_config, 0);
    tick();
    check("t5_config", db_estado, 6);
    check("t5_rec", receber_config, 1);
    tick();
    check("t5_ag_config", db_estado, 7);
    check("t5_rec_single", receber_config, 0);
    pronto_config = 1'b1; tick(); pronto_config = 1'b0;
    check("t5_back_espera", db_estado, 5);
    for (int i = 0; i < 5; i++) tick();
    definir_config = 1'b1; tick(); definir_config = 1'b0;
    tick();
    check("t5_config2", receber_config, 1);
    tick();
    pronto_config = 1'b1; tick(); pronto_config = 1'b0;
    check("t5_back_espera2", db_estado, 5);
    wait_medir(n, ntx);
    check("t5_delay_kept", n, 14);

    // test 6: pronto and erro together count as an error
    tick();
    pronto_medida = 1'b1; erro_medida = 1'b1; tick();
    pronto_medida = 1'b0; erro_medida = 1'b0;
    check("t6_medir", medir_dht11, 1);
    check("t6_tent", db_tentativas, 1);
    check("t6_no_tx", transmite_medida, 0);

    // start and definir_config together: config first, then the schedule
    reset = 1'b0; #1; reset = 1'b1;
    tick();
    start = 1'b1; definir_config = 1'b1; tick();
    start = 1'b0; definir_config = 1'b0;
    check("t7_config_first", db_estado, 6);
    check("t7_rec", receber_config, 1);
    tick();
    pronto_config = 1'b1; tick(); pronto_config = 1'b0;
    check("t7_back_inicial", db_estado, 0);
    tick();
    check("t7_latched_start", medir_dht11, 1);
    tick();
    check("t7_no_second_config", receber_config, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
